// File: rtl/if_stage_frontend_if.sv
// Bus bundle between the instruction-fetch front end and its surroundings.
// Groups the hazard-unit controls (PC_holdon, IFID_holdon, IFID_Flush), the
// redirect requests (Jump/true_branch and their targets), the instruction
// memory port (imem_addr/imem_rdata) and everything handed to the ID stage
// (IFID_*), plus the debug event counters.
//   master : the fetch front end (drives PC, imem_addr, IFID_*, counters)
//   slave  : the environment (hazard unit, ID/EX redirects, instruction memory)
interface if_stage_frontend_if #(
  parameter int unsigned CNT_W = 16
);
  logic             PC_holdon;
  logic             IFID_holdon;
  logic             IFID_Flush;
  logic             Jump;
  logic             true_branch;
  logic [31:0]      jump_target;
  logic [31:0]      branch_target;
  logic [31:0]      imem_rdata;
  logic [31:0]      imem_addr;
  logic [31:0]      PC;
  logic [31:0]      IFID_instruction;
  logic [31:0]      IFID_PC_plus4;
  logic             IFID_valid;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  PC_holdon, IFID_holdon, IFID_Flush, Jump, true_branch,
           jump_target, branch_target, imem_rdata,
    output imem_addr, PC, IFID_instruction, IFID_PC_plus4, IFID_valid,
           stall_cycles, flush_count
  );

  modport slave (
    output PC_holdon, IFID_holdon, IFID_Flush, Jump, true_branch,
           jump_target, branch_target, imem_rdata,
    input  imem_addr, PC, IFID_instruction, IFID_PC_plus4, IFID_valid,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/if_stage_frontend.sv
// Instruction-fetch front end: PC register, next-PC selection, IF/ID pipeline
// register and two saturating debug counters (hold cycles, IF/ID flushes).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : if_stage_frontend_if.master (controls, redirects, imem port,
//           IF/ID outputs, counters). The interface CNT_W must match CNT_W.
module if_stage_frontend #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  if_stage_frontend_if.master   bus
);

  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_reg;
  logic [31:0] ifid_pc4_reg;
  logic        ifid_valid_reg;

  logic        ifid_flush;
  logic        ifid_load;
  logic [1:0]  cnt_inc;

  assign pc_plus4 = pc_reg + 32'd4;  // wraps naturally modulo 2^32

  // A taken branch in EX is older than anything in IF/ID, so it flushes even
  // through a hold. Otherwise the hold wins over a hazard-unit flush so a
  // stalled jump stays in ID and re-resolves later.
  assign ifid_flush = bus.true_branch | (~bus.IFID_holdon & bus.IFID_Flush);
  assign ifid_load  = ~bus.true_branch & ~bus.IFID_holdon & ~bus.IFID_Flush;

  // Index 0: stall_cycles, index 1: flush_count.
  assign cnt_inc[0] = bus.IFID_holdon & ~bus.true_branch;
  assign cnt_inc[1] = ifid_flush;

  // PC register: branch > PC hold > jump > sequential. Targets are word
  // aligned on load so PC[1:0] stays 00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= {RESET_PC[31:2], 2'b00};
    end else if (bus.true_branch) begin
      pc_reg <= {bus.branch_target[31:2], 2'b00};
    end else if (!bus.PC_holdon) begin
      if (bus.Jump) begin
        pc_reg <= {bus.jump_target[31:2], 2'b00};
      end else begin
        pc_reg <= pc_plus4;
      end
    end
  end

  // IF/ID register. Flushed entries carry a defined bubble (no X leaks).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc4_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
    end else if (ifid_flush) begin
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc4_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
    end else if (ifid_load) begin
      ifid_instr_reg <= bus.imem_rdata;
      ifid_pc4_reg   <= pc_plus4;
      ifid_valid_reg <= 1'b1;
    end
  end

  // Saturating event counters: stop at all-ones instead of wrapping.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign bus.PC               = pc_reg;
  assign bus.imem_addr        = pc_reg;
  assign bus.IFID_instruction = ifid_instr_reg;
  assign bus.IFID_PC_plus4    = ifid_pc4_reg;
  assign bus.IFID_valid       = ifid_valid_reg;
  assign bus.stall_cycles     = g_cnt[0].count_reg;
  assign bus.flush_count      = g_cnt[1].count_reg;

endmodule

// File: tb/tb_if_stage_frontend.sv
module tb_if_stage_frontend;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] IMASK  = 32'hA5A5_0000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  if_stage_frontend_if #(.CNT_W(16)) bus();

  if_stage_frontend #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP),
    .CNT_W    (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Instruction memory: word at address A is A ^ A5A5_0000.
  assign bus.imem_rdata = bus.imem_addr ^ IMASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (architectural view of the fetch stage).
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = NOP;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
    m_stall = 16'd0;
    m_flush = 16'd0;
  endtask

  // One clock edge of the fetch stage, written from the priority rules.
  task automatic model_step();
    logic [31:0] new_pc;
    logic        flushed;
    if (bus.true_branch)      new_pc = bus.branch_target & ~32'd3;
    else if (bus.PC_holdon)   new_pc = m_pc;
    else if (bus.Jump)        new_pc = bus.jump_target & ~32'd3;
    else                      new_pc = m_pc + 32'd4;
    flushed = 1'b0;
    if (bus.true_branch) flushed = 1'b1;
    else if (bus.IFID_holdon) begin
      // IF/ID keeps its contents
    end else if (bus.IFID_Flush) flushed = 1'b1;
    else begin
      m_instr = m_pc ^ IMASK;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    if (flushed) begin
      m_instr = NOP;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
      if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
    if (bus.IFID_holdon && !bus.true_branch && m_stall != 16'hFFFF)
      m_stall = m_stall + 16'd1;
    m_pc = new_pc;
  endtask

  task automatic drive(input logic tb_, input logic ph, input logic ih,
                       input logic fl, input logic j,
                       input logic [31:0] bt, input logic [31:0] jt);
    bus.true_branch   = tb_;
    bus.PC_holdon     = ph;
    bus.IFID_holdon   = ih;
    bus.IFID_Flush    = fl;
    bus.Jump          = j;
    bus.branch_target = bt;
    bus.jump_target   = jt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (bus.PC !== RST_PC) begin bad++; $display("FAIL reset_pc: got %h expected %h", bus.PC, RST_PC); end
    total++; if (bus.IFID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.IFID_valid); end
    total++; if (bus.IFID_instruction !== NOP || bus.IFID_PC_plus4 !== 32'd0) begin bad++; $display("FAIL reset_ifid: got %h/%h expected %h/0", bus.IFID_instruction, bus.IFID_PC_plus4, NOP); end
    total++; if (bus.stall_cycles !== 16'd0 || bus.flush_count !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %h/%h expected 0/0", bus.stall_cycles, bus.flush_count); end
    reset = 1'b0;
    repeat (3) tick();
    total++; if (bus.PC !== 32'h0040_000C) begin bad++; $display("FAIL first_fetch_pc: got %h expected 0040000c", bus.PC); end
    total++; if (bus.IFID_PC_plus4 !== 32'h0040_000C) begin bad++; $display("FAIL first_fetch_pc4: got %h expected 0040000c", bus.IFID_PC_plus4); end
    total++; if (bus.IFID_instruction !== (32'h0040_0008 ^ IMASK) || bus.IFID_valid !== 1'b1) begin bad++; $display("FAIL first_fetch_instr: got %h v%b expected %h v1", bus.IFID_instruction, bus.IFID_valid, 32'h0040_0008 ^ IMASK); end
    $display("reset/first fetch: PC=%h IFID_PC_plus4=%h", bus.PC, bus.IFID_PC_plus4);
  endtask

  task automatic test_stall();
    logic [31:0] instr_before, pc4_before;
    tick();
    total++; if (bus.PC !== 32'h0040_0010) begin bad++; $display("FAIL stall_setup_pc: got %h expected 00400010", bus.PC); end
    instr_before = m_instr;
    pc4_before   = m_pc4;
    drive(0, 1, 1, 0, 0, 32'd0, 32'd0);
    tick();
    total++; if (bus.PC !== 32'h0040_0010) begin bad++; $display("FAIL stall_pc: got %h expected 00400010", bus.PC); end
    total++; if (bus.IFID_instruction !== instr_before || bus.IFID_PC_plus4 !== pc4_before) begin bad++; $display("FAIL stall_ifid: got %h/%h expected %h/%h", bus.IFID_instruction, bus.IFID_PC_plus4, instr_before, pc4_before); end
    total++; if (bus.stall_cycles !== 16'd1) begin bad++; $display("FAIL stall_count: got %0d expected 1", bus.stall_cycles); end
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    total++; if (bus.PC !== 32'h0040_0014 || bus.IFID_PC_plus4 !== 32'h0040_0014) begin bad++; $display("FAIL stall_resume: got PC %h pc4 %h expected 00400014/00400014", bus.PC, bus.IFID_PC_plus4); end
    $display("stall: PC=%h stall_cycles=%0d", bus.PC, bus.stall_cycles);
  endtask

  task automatic test_jump_flush();
    drive(0, 0, 0, 1, 1, 32'd0, 32'h0040_0103);
    tick();
    total++; if (bus.PC !== 32'h0040_0100) begin bad++; $display("FAIL jump_pc: got %h expected 00400100", bus.PC); end
    total++; if (bus.IFID_valid !== 1'b0 || bus.IFID_instruction !== 32'h0) begin bad++; $display("FAIL jump_flush_ifid: got v%b %h expected v0 00000000", bus.IFID_valid, bus.IFID_instruction); end
    total++; if (bus.flush_count !== 16'd1) begin bad++; $display("FAIL jump_flush_count: got %0d expected 1", bus.flush_count); end
    $display("jump+flush: PC=%h flush_count=%0d", bus.PC, bus.flush_count);
  endtask

  task automatic test_branch_priority();
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    drive(1, 1, 1, 0, 1, 32'h0040_0200, 32'h0040_0300);
    tick();
    total++; if (bus.PC !== 32'h0040_0200) begin bad++; $display("FAIL branch_pc: got %h expected 00400200", bus.PC); end
    total++; if (bus.IFID_valid !== 1'b0 || bus.IFID_PC_plus4 !== 32'd0) begin bad++; $display("FAIL branch_flush: got v%b pc4 %h expected v0 0", bus.IFID_valid, bus.IFID_PC_plus4); end
    total++; if (bus.stall_cycles !== 16'd1 || bus.flush_count !== 16'd2) begin bad++; $display("FAIL branch_counts: got stall %0d flush %0d expected 1/2", bus.stall_cycles, bus.flush_count); end
    $display("branch priority: PC=%h stall=%0d flush=%0d", bus.PC, bus.stall_cycles, bus.flush_count);
  endtask

  task automatic test_held_jump();
    logic [31:0] pc_b, instr_b, pc4_b;
    logic [15:0] fc_b;
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    pc_b = bus.PC; instr_b = m_instr; pc4_b = m_pc4; fc_b = m_flush;
    drive(0, 1, 1, 1, 1, 32'd0, 32'h0040_0300);
    tick();
    total++; if (bus.PC !== pc_b || bus.IFID_instruction !== instr_b || bus.IFID_PC_plus4 !== pc4_b || bus.IFID_valid !== 1'b1) begin bad++; $display("FAIL held_jump_hold: got %h %h %h v%b expected %h %h %h v1", bus.PC, bus.IFID_instruction, bus.IFID_PC_plus4, bus.IFID_valid, pc_b, instr_b, pc4_b); end
    total++; if (bus.flush_count !== fc_b) begin bad++; $display("FAIL held_jump_flushcnt: got %0d expected %0d", bus.flush_count, fc_b); end
    drive(0, 0, 0, 0, 1, 32'd0, 32'h0040_0300);
    tick();
    total++; if (bus.PC !== 32'h0040_0300) begin bad++; $display("FAIL held_jump_taken: got %h expected 00400300", bus.PC); end
    $display("held jump: PC=%h flush=%0d", bus.PC, bus.flush_count);
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'd0);
    tick();
    total++; if (bus.PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load: got %h expected fffffffc", bus.PC); end
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    total++; if (bus.PC !== 32'd0 || bus.imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_pc: got %h addr %h expected 0", bus.PC, bus.imem_addr); end
    total++; if (bus.IFID_PC_plus4 !== 32'd0 || bus.IFID_valid !== 1'b1 || bus.IFID_instruction !== (32'hFFFF_FFFC ^ IMASK)) begin bad++; $display("FAIL wrap_ifid: got pc4 %h v%b %h expected 0 v1 %h", bus.IFID_PC_plus4, bus.IFID_valid, bus.IFID_instruction, 32'hFFFF_FFFC ^ IMASK); end
    $display("wrap: PC=%h IFID_PC_plus4=%h", bus.PC, bus.IFID_PC_plus4);
  endtask

  task automatic test_saturation();
    drive(0, 0, 1, 0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 65540; i++) tick();
    total++; if (bus.stall_cycles !== 16'hFFFF || m_stall !== 16'hFFFF) begin bad++; $display("FAIL stall_saturate: got %h expected ffff", bus.stall_cycles); end
    total++; if (bus.PC !== m_pc) begin bad++; $display("FAIL saturate_pc: got %h expected %h", bus.PC, m_pc); end
    $display("saturation: stall_cycles=%h", bus.stall_cycles);
  endtask

  task automatic test_async_reset();
    // Still holding from the previous scenario; reset lands mid-cycle.
    #1;
    reset = 1'b1;
    #1;
    total++; if (bus.PC !== RST_PC || bus.imem_addr !== RST_PC) begin bad++; $display("FAIL async_pc: got %h expected %h", bus.PC, RST_PC); end
    total++; if (bus.IFID_valid !== 1'b0 || bus.IFID_instruction !== NOP || bus.IFID_PC_plus4 !== 32'd0) begin bad++; $display("FAIL async_ifid: got v%b %h %h expected v0 %h 0", bus.IFID_valid, bus.IFID_instruction, bus.IFID_PC_plus4, NOP); end
    total++; if (bus.stall_cycles !== 16'd0 || bus.flush_count !== 16'd0) begin bad++; $display("FAIL async_cnt: got %h/%h expected 0/0", bus.stall_cycles, bus.flush_count); end
    #1;
    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    total++; if (bus.PC !== (RST_PC + 32'd4) || bus.IFID_instruction !== (RST_PC ^ IMASK)) begin bad++; $display("FAIL async_restart: got %h %h expected %h %h", bus.PC, bus.IFID_instruction, RST_PC + 32'd4, RST_PC ^ IMASK); end
    $display("async reset: PC=%h stall=%0d", bus.PC, bus.stall_cycles);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom, $urandom);
      tick();
      total++;
      if (bus.PC !== m_pc || bus.imem_addr !== m_pc || bus.IFID_instruction !== m_instr ||
          bus.IFID_PC_plus4 !== m_pc4 || bus.IFID_valid !== m_valid ||
          bus.stall_cycles !== m_stall || bus.flush_count !== m_flush) begin
        bad++; errs++;
        $display("FAIL random_%0d: got pc %h ins %h pc4 %h v%b st %0d fl %0d expected pc %h ins %h pc4 %h v%b st %0d fl %0d",
                 i, bus.PC, bus.IFID_instruction, bus.IFID_PC_plus4, bus.IFID_valid, bus.stall_cycles, bus.flush_count,
                 m_pc, m_instr, m_pc4, m_valid, m_stall, m_flush);
      end
    end
    $display("random: 400 cycles, %0d mismatching", errs);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    model_reset();
    test_reset();
    test_stall();
    test_jump_flush();
    test_branch_priority();
    test_held_jump();
    test_wrap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage_frontend.md
Name: if_stage_frontend

Overview:
- Instruction-fetch front end of the 5-stage pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Sits directly downstream of the control-hazard unit and consumes its flush/hold outputs, together with the raw Jump / true_branch redirects.
- Drives the instruction-memory address and feeds the ID stage.
- Also keeps saturating stall/flush event counters for debug.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush and reset.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC_holdon  input  1  freeze PC this cycle (load-use stall).
- IFID_holdon  input  1  freeze IF/ID register this cycle.
- IFID_Flush  input  1  replace IF/ID contents with bubble.
- Jump  input  1  ID-stage jump redirect.
- true_branch  input  1  EX-stage taken-branch redirect.
- jump_target  input  32  jump destination.
- branch_target  input  32  branch destination.
- imem_rdata  input  32  instruction word at imem_addr, combinational read.
- imem_addr  output  32  equals PC.
- PC  output  32  current fetch PC.
- IFID_instruction  output  32  registered instruction to ID.
- IFID_PC_plus4  output  32  registered PC+4 of that instruction.
- IFID_valid  output  1  1 = real instruction, 0 = bubble.
- stall_cycles  output  CNT_W  count of hold cycles, saturating.
- flush_count  output  CNT_W  count of IF/ID flushes, saturating.

Behaviour:
- Reset (async, immediate, any time including mid-stall or mid-redirect):
  - PC = RESET_PC.
  - IFID_instruction = NOP_INSTR, IFID_PC_plus4 = 0, IFID_valid = 0.
  - Both counters = 0.
- First valid fetch is latched on the first rising edge after reset deasserts.
- imem_addr = PC, purely combinational. Fetch latency: the instruction at PC appears on IFID_* one edge later.
- Next-PC priority, evaluated each rising edge:
  1. true_branch: PC <= branch_target. The branch in EX is older and overrides any stall.
  2. else PC_holdon: PC unchanged.
  3. else Jump: PC <= jump_target.
  4. else PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Targets are loaded with bits [1:0] forced to 00; PC[1:0] is always 00.
- IF/ID priority, evaluated each rising edge:
  1. true_branch: flush, i.e. instr = NOP_INSTR, PC_plus4 = 0, valid = 0.
  2. else IFID_holdon: all IF/ID fields hold, the hold beating IFID_Flush. A stalled jump stays in ID and re-resolves once the stall clears; no instruction is lost.
  3. else IFID_Flush: flush.
  4. else load instr = imem_rdata, PC_plus4 = PC + 4 (same wrap rule), valid = 1.
- PC_holdon and IFID_holdon are honoured independently; a mismatched pair is not an error.
- stall_cycles: +1 on each edge where IFID_holdon = 1 and true_branch = 0.
- flush_count: +1 on each edge where IF/ID is flushed by rule 1 or rule 3.
- Both counters saturate at all-ones and never wrap.
- Outputs are registered except imem_addr, which is a direct copy of PC.
- No X propagates from the IF/ID outputs after reset.

Test Plan:
- Reset assertion then release, imem returns addr^32'hA5A5_0000:
  - PC = 32'h0040_0000 during reset, IFID_valid = 0.
  - After 3 edges: PC = 32'h0040_000C, IFID_PC_plus4 = 32'h0040_000C.
- Load-use stall for 1 cycle with PC = 32'h0040_0010:
  - PC stays 32'h0040_0010 and IF/ID fields are unchanged for that edge.
  - stall_cycles = 1.
  - Fetch resumes at 32'h0040_0014 on the next edge.
- Jump = 1, IFID_Flush = 1, jump_target = 32'h0040_0103:
  - PC = 32'h0040_0100.
  - IFID_valid = 0, IFID_instruction = 32'h0.
  - flush_count = 1.
- Simultaneous true_branch, loaduse hold and Jump, branch_target = 32'h0040_0200, jump_target = 32'h0040_0300:
  - PC = 32'h0040_0200 and IF/ID flushed.
  - stall_cycles is not incremented.
- Jump with PC_holdon = IFID_holdon = IFID_Flush = 1:
  - PC and IF/ID both hold, and flush_count is not incremented.
  - Next cycle, hold deasserted: jump is taken.
- Wrap and saturation:
  - Force PC = 32'hFFFF_FFFC via branch_target: next PC = 0 and IFID_PC_plus4 = 0.
  - Hold IFID_holdon for 65540 cycles: stall_cycles stays at 16'hFFFF.
  - Asynchronous reset mid-hold clears all outputs and both counters before the next edge.
